// File: rtl/uart_loader.sv
// uart_loader
// Program loader that sits directly behind the UART receiver. It turns the
// receiver's toggle-per-byte strobe into byte events and parses a frame made
// of a 32-bit little-endian word count followed by that many little-endian
// 32-bit words. The words are written to instruction memory from word
// address 0 upward. The CPU is held in reset while a frame is in progress.
//
// Parameters
//   ADDR_WIDTH     memory word-address width; a frame holds up to 2^ADDR_WIDTH words
//   TIMEOUT_CYCLES idle clocks allowed between bytes inside a frame
//   TIMEOUT_WIDTH  width of the idle counter; must hold TIMEOUT_CYCLES-1
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   rx_update  in   receiver strobe; every transition marks one new byte
//   rx_byte    in   received byte, valid when rx_update has just toggled
//   mem_we     out  one-cycle instruction-memory write enable
//   mem_addr   out  word address of the write
//   mem_wdata  out  write data
//   cpu_hold   out  high while a frame is in progress
//   load_done  out  one-cycle pulse when a frame completes successfully
//   error      out  sticky frame-error flag, cleared by the next frame's first byte
module uart_loader #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 2517500,
  parameter int TIMEOUT_WIDTH  = 22
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_update,
  input  logic [7:0]            rx_byte,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  error
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HEADER = 2'd1;
  localparam logic [1:0] DATA   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // Largest legal word count; one bit wider than a 32-bit count so the
  // comparison is exact for any ADDR_WIDTH up to 32.
  localparam logic [32:0] CAPACITY = 33'd1 << ADDR_WIDTH;
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]               state;
  logic                     rx_update_q;
  logic                     primed;
  logic [1:0]               byte_idx;
  logic [31:0]              shift;
  logic [31:0]              assembled;
  logic [ADDR_WIDTH:0]      frame_len;
  logic [ADDR_WIDTH:0]      word_idx;
  logic [ADDR_WIDTH:0]      next_word;
  logic [TIMEOUT_WIDTH-1:0] timer;
  logic                     byte_event;
  logic                     timed_out;

  // primed stays low for the first clock after reset so that rx_update
  // already sitting at 1 when reset releases is not mistaken for a byte.
  assign byte_event = primed & (rx_update ^ rx_update_q);
  assign next_word  = word_idx + 1'b1;
  assign timed_out  = (state == HEADER || state == DATA) && !byte_event &&
                      (timer == TIMEOUT_LAST);

  // The word as it will look once the incoming byte is merged into its lane.
  always_comb begin
    assembled = shift;
    case (byte_idx)
      2'd0:    assembled[7:0]   = rx_byte;
      2'd1:    assembled[15:8]  = rx_byte;
      2'd2:    assembled[23:16] = rx_byte;
      default: assembled[31:24] = rx_byte;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rx_update_q <= 1'b0;
      primed      <= 1'b0;
      byte_idx    <= 2'd0;
      shift       <= 32'd0;
      frame_len   <= '0;
      word_idx    <= '0;
      timer       <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 32'd0;
      cpu_hold    <= 1'b0;
      load_done   <= 1'b0;
      error       <= 1'b0;
    end else begin
      rx_update_q <= rx_update;
      primed      <= 1'b1;
      mem_we      <= 1'b0;
      load_done   <= 1'b0;

      if (byte_event || state == IDLE || state == DONE)
        timer <= '0;
      else
        timer <= timer + 1'b1;

      case (state)
        IDLE: begin
          if (byte_event) begin
            shift    <= assembled;
            byte_idx <= 2'd1;
            cpu_hold <= 1'b1;
            error    <= 1'b0;
            state    <= HEADER;
          end
        end

        HEADER: begin
          if (byte_event) begin
            shift    <= assembled;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              if (assembled == 32'd0) begin
                load_done <= 1'b1;
                cpu_hold  <= 1'b0;
                state     <= IDLE;
              end else if ({1'b0, assembled} > CAPACITY) begin
                error    <= 1'b1;
                cpu_hold <= 1'b0;
                state    <= IDLE;
              end else begin
                frame_len <= assembled[ADDR_WIDTH:0];
                word_idx  <= '0;
                state     <= DATA;
              end
            end
          end else if (timed_out) begin
            error    <= 1'b1;
            cpu_hold <= 1'b0;
            byte_idx <= 2'd0;
            state    <= IDLE;
          end
        end

        DATA: begin
          if (byte_event) begin
            shift    <= assembled;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_idx[ADDR_WIDTH-1:0];
              mem_wdata <= assembled;
              word_idx  <= next_word;
              if (next_word == frame_len)
                state <= DONE;
            end
          end else if (timed_out) begin
            error    <= 1'b1;
            cpu_hold <= 1'b0;
            byte_idx <= 2'd0;
            state    <= IDLE;
          end
        end

        // One cycle after the final write: report completion. A byte that
        // arrives in this very cycle opens the next frame instead of being lost.
        default: begin
          load_done <= 1'b1;
          cpu_hold  <= 1'b0;
          state     <= IDLE;
          if (byte_event) begin
            shift    <= assembled;
            byte_idx <= 2'd1;
            cpu_hold <= 1'b1;
            error    <= 1'b0;
            state    <= HEADER;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader with a 16-word memory and a short
// inter-byte timeout. Frames are built from random words; the expected write
// sequence, completion and cpu_hold duration are derived from the frame
// contents and the byte timing recorded while sending.
module tb_uart_loader;

  localparam int AW      = 4;
  localparam int TIMEOUT = 40;
  localparam int TW      = 6;
  localparam int CAP     = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          rx_update;
  logic [7:0]    rx_byte;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          error;

  int checks = 0;
  int errors = 0;

  int cycleNum = 0;
  int firstEdge;
  int lastEdge;
  int holdCycles;
  int doneCount;
  int unsigned wrAddr[$];
  logic [31:0] wrData[$];
  logic [31:0] frameWords[0:31];

  uart_loader #(
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TIMEOUT),
    .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_update(rx_update),
    .rx_byte(rx_byte),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold),
    .load_done(load_done),
    .error(error)
  );

  // Free-running clock and cycle counter used to timestamp byte edges.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycleNum = cycleNum + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Monitor on the falling edge: log writes, count completions and hold time.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_hold) holdCycles++;
      if (mem_we) begin
        wrAddr.push_back(int'(mem_addr));
        wrData.push_back(mem_wdata);
        checkOutput("hold_during_write", {31'd0, cpu_hold}, 32'd1);
      end
      if (load_done) begin
        doneCount++;
        checkOutput("hold_low_at_done", {31'd0, cpu_hold}, 32'd0);
      end
    end
  end

  // Present one byte after 'gap' idle clocks; it is consumed on the next edge.
  task automatic sendByte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    @(posedge clk);
    #1;
    rx_byte   = b;
    rx_update = ~rx_update;
    lastEdge  = cycleNum + 1;
  endtask

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
    holdCycles = 0;
    doneCount  = 0;
  endtask

  // Send a whole frame: header with 'count', then the data words unless the
  // count exceeds capacity (the loader then rejects after the header).
  task automatic applyStimulus(input int count, input int gapMax);
    logic [31:0] hdr;
    logic [31:0] w;
    clearLog();
    hdr = 32'(count);
    for (int i = 0; i < 4; i++) begin
      sendByte(hdr[8*i +: 8], $urandom_range(gapMax, 0));
      if (i == 0) firstEdge = lastEdge;
    end
    if (count <= CAP) begin
      for (int k = 0; k < count; k++) begin
        w = frameWords[k];
        for (int i = 0; i < 4; i++)
          sendByte(w[8*i +: 8], $urandom_range(gapMax, 0));
      end
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  // Expected outcome of a frame derived from its count and byte timing.
  task automatic verifyFrame(input string name, input int count);
    if (count > CAP) begin
      checkOutput({name, "_writes"}, 32'(wrAddr.size()), 32'd0);
      checkOutput({name, "_done"}, 32'(doneCount), 32'd0);
      checkOutput({name, "_error"}, {31'd0, error}, 32'd1);
      checkOutput({name, "_hold_cycles"}, 32'(holdCycles), 32'(lastEdge - firstEdge));
    end else begin
      checkOutput({name, "_writes"}, 32'(wrAddr.size()), 32'(count));
      checkOutput({name, "_done"}, 32'(doneCount), 32'd1);
      checkOutput({name, "_error"}, {31'd0, error}, 32'd0);
      if (count == 0)
        checkOutput({name, "_hold_cycles"}, 32'(holdCycles), 32'(lastEdge - firstEdge));
      else
        checkOutput({name, "_hold_cycles"}, 32'(holdCycles), 32'(lastEdge - firstEdge + 1));
      for (int i = 0; i < count && i < wrAddr.size(); i++) begin
        checkOutput({name, "_addr"}, 32'(wrAddr[i]), 32'(i));
        checkOutput({name, "_data"}, wrData[i], frameWords[i]);
      end
    end
    checkOutput({name, "_hold_after"}, {31'd0, cpu_hold}, 32'd0);
  endtask

  initial begin
    int cnt;
    rst_n     = 1'b0;
    rx_update = 1'b1;
    rx_byte   = 8'h00;
    clearLog();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("reset_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("reset_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset_wdata", mem_wdata, 32'd0);

    // Release reset with rx_update already high: no byte must be seen.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("primed_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("primed_error", {31'd0, error}, 32'd0);
    checkOutput("primed_writes", 32'(wrAddr.size()), 32'd0);
    checkOutput("primed_done", 32'(doneCount), 32'd0);

    // Two-word program, back-to-back bytes.
    frameWords[0] = 32'h0000_0013;
    frameWords[1] = 32'h0000_006F;
    applyStimulus(2, 0);
    verifyFrame("two_word", 2);

    applyStimulus(0, 0);
    verifyFrame("zero_len", 0);

    applyStimulus(CAP + 1, 0);
    verifyFrame("over_cap", CAP + 1);

    for (int i = 0; i < CAP; i++) frameWords[i] = $urandom;
    applyStimulus(CAP, 0);
    verifyFrame("full_cap", CAP);

    // Timeout: count 1, two data bytes, then silence.
    clearLog();
    sendByte(8'h01, 0);
    sendByte(8'h00, 0);
    sendByte(8'h00, 0);
    sendByte(8'h00, 0);
    sendByte(8'hAA, 0);
    sendByte(8'hBB, 0);
    repeat (TIMEOUT) @(posedge clk);
    @(negedge clk);
    checkOutput("timeout_not_yet", {31'd0, error}, 32'd0);
    @(negedge clk);
    checkOutput("timeout_error", {31'd0, error}, 32'd1);
    checkOutput("timeout_hold", {31'd0, cpu_hold}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("timeout_writes", 32'(wrAddr.size()), 32'd0);
    checkOutput("timeout_done", 32'(doneCount), 32'd0);

    // Next frame clears error on its first byte and loads from address 0.
    clearLog();
    frameWords[0] = $urandom;
    sendByte(8'h01, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("recover_error_clear", {31'd0, error}, 32'd0);
    checkOutput("recover_hold", {31'd0, cpu_hold}, 32'd1);
    sendByte(8'h00, 0);
    sendByte(8'h00, 0);
    sendByte(8'h00, 0);
    for (int i = 0; i < 4; i++) sendByte(frameWords[0][8*i +: 8], 0);
    repeat (6) @(negedge clk);
    checkOutput("recover_writes", 32'(wrAddr.size()), 32'd1);
    checkOutput("recover_done", 32'(doneCount), 32'd1);
    if (wrAddr.size() > 0) begin
      checkOutput("recover_addr", 32'(wrAddr[0]), 32'd0);
      checkOutput("recover_data", wrData[0], frameWords[0]);
    end

    // Random frames with random inter-byte gaps.
    for (int f = 0; f < 8; f++) begin
      cnt = $urandom_range(CAP + 1, 0);
      for (int i = 0; i < CAP; i++) frameWords[i] = $urandom;
      applyStimulus(cnt, 3);
      verifyFrame("random", cnt);
    end

    // Reset mid-DATA after the second word.
    clearLog();
    sendByte(8'h04, 0);
    sendByte(8'h00, 0);
    sendByte(8'h00, 0);
    sendByte(8'h00, 0);
    for (int i = 0; i < 10; i++) sendByte(8'($urandom), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("midreset_addr", 32'(mem_addr), 32'd0);
    checkOutput("midreset_wdata", mem_wdata, 32'd0);
    checkOutput("midreset_we", {31'd0, mem_we}, 32'd0);
    checkOutput("midreset_prior_writes", 32'(wrAddr.size()), 32'd2);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 2; i++) frameWords[i] = $urandom;
    applyStimulus(2, 1);
    verifyFrame("after_reset", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety bound so the bench always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
